// File: rtl/icache.sv
// icache: direct-mapped read-only instruction cache, one word per frame, fills from memory on miss
//   CLK/nRST            clock (rising edge), async active-low reset
//   imemREN/imemaddr    datapath fetch request and byte address ([1:0] ignored)
//   ihit/imemload       combinational hit and fetched word (imemload valid only with ihit)
//   iREN/iaddr          miss-fill read request and word-aligned address to memory
//   iwait/iload         memory busy flag and read data (valid when iREN && !iwait)
//   hit_count/miss_count  present only when ICACHE_STATS_EN is defined
module icache #(
  parameter int SETS   = 16,
  parameter int WORD_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              imemREN,
  input  logic [WORD_W-1:0] imemaddr,
  output logic              ihit,
  output logic [WORD_W-1:0] imemload,
  output logic              iREN,
  output logic [WORD_W-1:0] iaddr,
  input  logic              iwait,
  input  logic [WORD_W-1:0] iload
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);
  localparam int IDXW = $clog2(SETS);
  localparam int TW   = WORD_W - IDXW - 2;
  typedef enum logic {IDLE, FILL} state_t;
  state_t state, next_state;
  logic [SETS-1:0]   valid;
  logic [TW-1:0]     tags [SETS];
  logic [WORD_W-1:0] data [SETS];
  logic [WORD_W-1:0] fill_addr;
  logic [IDXW-1:0]   idx, fidx;
  logic              hit, fill_done, miss_start;
  assign idx        = imemaddr[IDXW+1:2];
  assign fidx       = fill_addr[IDXW+1:2];
  assign hit        = imemREN && valid[idx] && tags[idx] == imemaddr[WORD_W-1:IDXW+2];
  assign fill_done  = state == FILL && !iwait;
  assign miss_start = state == IDLE && next_state == FILL;
  always_comb begin
    next_state = state;
    ihit       = 1'b0;
    imemload   = '0;
    iREN       = 1'b0;
    iaddr      = '0;
    if (state == IDLE) begin
      ihit       = hit;
      imemload   = hit ? data[idx] : '0;
      next_state = imemREN && !hit ? FILL : IDLE;
    end else begin
      iREN       = 1'b1;
      iaddr      = fill_addr;
      next_state = iwait ? FILL : IDLE;
    end
  end
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      valid     <= '0;
      fill_addr <= '0;
    end else begin
      state <= next_state;
      if (miss_start) fill_addr <= imemaddr & ~WORD_W'(3);
      if (fill_done) valid[fidx] <= 1'b1;
    end
  end
  // Tag/data arrays need no reset: valid gates every use, and a reset
  // forces IDLE so an abandoned fill never writes.
  always_ff @(posedge CLK) begin
    if (fill_done) begin
      tags[fidx] <= fill_addr[WORD_W-1:IDXW+2];
      data[fidx] <= iload;
    end
  end
`ifdef ICACHE_STATS_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (ihit) hit_count <= hit_count + 32'd1;
      if (miss_start) miss_count <= miss_count + 32'd1;
    end
  end
`endif
endmodule
